// File: rtl/updown_counter_mod.sv
// updown_counter_mod: up/down modulo-(MAX+1) counter with prescaler, clear/load and terminal-count pulse.
// Define UDCNT_SATURATE_EN to hold at MAX/0 on a boundary step instead of wrapping.
module updown_counter_mod #(
    parameter int WIDTH = 6,
    parameter int MAX   = 63,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d, step_v, edge_v;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tc_q, tc_d, bnd;

    assign bnd    = dir ? (cnt_q == '0) : (cnt_q == MAXV);
    assign step_v = dir ? cnt_q - 1'b1 : cnt_q + 1'b1;
`ifdef UDCNT_SATURATE_EN
    assign edge_v = cnt_q;
`else
    assign edge_v = dir ? MAXV : '0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
        tc_d   = 1'b0;
        if (clr) begin
            cnt_d  = dir ? MAXV : '0;
            pcnt_d = '0;
        end else if (load) begin
            cnt_d  = (load_val > MAXV) ? MAXV : load_val;
            pcnt_d = '0;
        end else if (en && pcnt_q == PLAST) begin
            pcnt_d = '0;
            tc_d   = bnd;
            cnt_d  = bnd ? edge_v : step_v;
        end else if (en) begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pcnt_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            tc_q   <= tc_d;
        end
    end

    assign counter = cnt_q;
    assign tc      = tc_q;
    assign at_max  = (cnt_q == MAXV);
    assign at_min  = (cnt_q == '0);
endmodule
